dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port, registered-read data RAM (1024 x 32, word-addressed by addr>>2, no byte enables).
- Port 0 serves the pipeline MEM stage; port 1 serves the program loader/debug master.
- Grants one access per free cycle and returns read data to the correct owner one cycle later.
- Performs sub-word stores as a two-cycle read-modify-write, because the RAM only writes full words.

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data RAM.
interface dmem_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic [3:0]  p0_be;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p0_err;

    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [3:0]  p1_be;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        p1_err;

    logic        ram_wen;
    logic        ram_ren;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    // Arbiter side
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_be,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_be,
        input  ram_rdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output ram_wen, ram_ren, ram_addr, ram_wdata
    );

    // Requester / RAM side
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_be,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_be,
        output ram_rdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  ram_wen, ram_ren, ram_addr, ram_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port registered-read data RAM.
// Reads return one cycle after grant; partial stores become read-modify-write.
module dmem_arbiter #(
    parameter int MEM_WORDS  = 1024,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t      state, state_nxt;
    logic        rd_pending, rd_owner, rd_err, last_grant;
    logic [29:0] rmw_word;
    logic [31:0] rmw_wdata;
    logic [3:0]  rmw_be;

    logic        gnt0, gnt1, any_gnt;
    logic        g_we, g_oor;
    logic [31:0] g_addr, g_wdata;
    logic [3:0]  g_be;
    logic [31:0] merged;
    logic        wen, ren;
    logic [31:0] raddr, wdata;
    logic        v0, v1;

    // Address low bits are don't-care: the RAM is word addressed.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.p0_addr[1:0], bus.p1_addr[1:0]};

    // Arbitration: grants only in IDLE and never while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && state == IDLE) begin
            if (bus.p0_req && (!bus.p1_req || FIXED_PRIO || last_grant))
                gnt0 = 1'b1;
            else if (bus.p1_req)
                gnt1 = 1'b1;
        end
    end

    assign any_gnt = gnt0 | gnt1;
    assign g_we    = gnt1 ? bus.p1_we    : bus.p0_we;
    assign g_addr  = gnt1 ? bus.p1_addr  : bus.p0_addr;
    assign g_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;
    assign g_be    = gnt1 ? bus.p1_be    : bus.p0_be;
    assign g_oor   = {1'b0, g_addr[31:2]} >= 31'(MEM_WORDS);

    // Byte merge of latched store data over the word just read back.
    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = rmw_be[i] ? rmw_wdata[8*i +: 8] : bus.ram_rdata[8*i +: 8];
    end

    // Next state and RAM command; address/data stay 0 unless an enable is up.
    always_comb begin
        state_nxt = state;
        wen       = 1'b0;
        ren       = 1'b0;
        raddr     = '0;
        wdata     = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (any_gnt && !g_oor) begin
                        if (!g_we) begin
                            ren   = 1'b1;
                            raddr = {g_addr[31:2], 2'b00};
                        end else if (g_be == 4'hF) begin
                            wen   = 1'b1;
                            raddr = {g_addr[31:2], 2'b00};
                            wdata = g_wdata;
                        end else if (g_be != 4'h0) begin
                            ren       = 1'b1;
                            raddr     = {g_addr[31:2], 2'b00};
                            state_nxt = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    wen       = 1'b1;
                    raddr     = {rmw_word, 2'b00};
                    wdata     = merged;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, read-response tracking, round-robin pointer and RMW latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
            rd_err     <= 1'b0;
            last_grant <= 1'b1;
            rmw_word   <= '0;
            rmw_wdata  <= '0;
            rmw_be     <= '0;
        end else begin
            state      <= state_nxt;
            rd_pending <= any_gnt && !g_we;
            rd_owner   <= gnt1;
            rd_err     <= g_oor;
            if (any_gnt)
                last_grant <= gnt1;
            if (any_gnt && g_we) begin
                rmw_word  <= g_addr[31:2];
                rmw_wdata <= g_wdata;
                rmw_be    <= g_be;
            end
        end
    end

    assign v0 = rd_pending && !rd_owner;
    assign v1 = rd_pending &&  rd_owner;

    assign bus.p0_gnt    = gnt0;
    assign bus.p1_gnt    = gnt1;
    assign bus.p0_rvalid = v0;
    assign bus.p1_rvalid = v1;
    assign bus.p0_rdata  = (v0 && !rd_err) ? bus.ram_rdata : '0;
    assign bus.p1_rdata  = (v1 && !rd_err) ? bus.ram_rdata : '0;
    assign bus.p0_err    = v0 && rd_err;
    assign bus.p1_err    = v1 && rd_err;
    assign bus.ram_wen   = wen;
    assign bus.ram_ren   = ren;
    assign bus.ram_addr  = raddr;
    assign bus.ram_wdata = wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a behavioural RAM.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic loading = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();
    dmem_arbiter_if bus_fp ();

    dmem_arbiter #(.MEM_WORDS(1024), .FIXED_PRIO(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    dmem_arbiter #(.MEM_WORDS(1024), .FIXED_PRIO(1'b1)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

    // Registered-read RAM, preloaded while 'loading' is high
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (loading) begin
            mem[0] <= 32'h0000_1000;
            mem[1] <= 32'h0000_1004;
            mem[2] <= 32'h0000_1008;
            mem[4] <= 32'h0;
            mem[8] <= 32'h1122_3344;
        end else begin
            if (bus.ram_wen) mem[bus.ram_addr[11:2]] <= bus.ram_wdata;
            if (bus.ram_ren) bus.ram_rdata <= mem[bus.ram_addr[11:2]];
        end
    end
    assign bus_fp.ram_rdata = 32'h0;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } preq_t;

    typedef struct packed {
        logic        g0, g1, v0;
        logic [31:0] d0;
        logic        e0, v1;
        logic [31:0] d1;
        logic        e1, wen, ren;
        logic [31:0] a, wd;
    } out_t;

    typedef struct packed {
        preq_t p0;
        preq_t p1;
        out_t  exp;
    } vec_t;

    int checks = 0;
    int failures = 0;

    function automatic preq_t nr();
        return '0;
    endfunction
    function automatic preq_t rd(input logic [31:0] a);
        preq_t r = '0;
        r.req = 1'b1; r.addr = a;
        return r;
    endfunction
    function automatic preq_t wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        preq_t r;
        r.req = 1'b1; r.we = 1'b1; r.addr = a; r.wdata = d; r.be = be;
        return r;
    endfunction
    function automatic out_t o(input logic g0, input logic g1,
                               input logic v0, input logic [31:0] d0, input logic e0,
                               input logic v1, input logic [31:0] d1, input logic e1,
                               input logic wen, input logic ren,
                               input logic [31:0] a, input logic [31:0] wd);
        out_t r;
        r.g0 = g0; r.g1 = g1; r.v0 = v0; r.d0 = d0; r.e0 = e0;
        r.v1 = v1; r.d1 = d1; r.e1 = e1; r.wen = wen; r.ren = ren; r.a = a; r.wd = wd;
        return r;
    endfunction
    function automatic vec_t mk(input preq_t a, input preq_t b, input out_t e);
        vec_t v;
        v.p0 = a; v.p1 = b; v.exp = e;
        return v;
    endfunction

    function automatic out_t sample();
        return o(bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p0_rdata, bus.p0_err,
                 bus.p1_rvalid, bus.p1_rdata, bus.p1_err,
                 bus.ram_wen, bus.ram_ren, bus.ram_addr, bus.ram_wdata);
    endfunction

    task automatic drive(input preq_t a, input preq_t b);
        bus.p0_req = a.req; bus.p0_we = a.we; bus.p0_addr = a.addr; bus.p0_wdata = a.wdata; bus.p0_be = a.be;
        bus.p1_req = b.req; bus.p1_we = b.we; bus.p1_addr = b.addr; bus.p1_wdata = b.wdata; bus.p1_be = b.be;
    endtask

    task automatic chk(input string name, input out_t exp);
        out_t got;
        got = sample();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    localparam out_t Z = '0;
    localparam int NV = 25;
    vec_t vecs [NV];

    initial begin
        // g0 g1 | v0 d0 e0 | v1 d1 e1 | wen ren addr wdata
        vecs[0]  = mk(nr(), nr(), Z);
        vecs[1]  = mk(wr(32'h10, 32'hDEADBEEF, 4'hF), nr(), o(1,0, 0,0,0, 0,0,0, 1,0, 32'h10, 32'hDEADBEEF));
        vecs[2]  = mk(rd(32'h10), nr(), o(1,0, 0,0,0, 0,0,0, 0,1, 32'h10, 0));
        vecs[3]  = mk(nr(), nr(), o(0,0, 1,32'hDEADBEEF,0, 0,0,0, 0,0, 0, 0));
        vecs[4]  = mk(rd(32'h0), nr(), o(1,0, 0,0,0, 0,0,0, 0,1, 32'h0, 0));
        vecs[5]  = mk(rd(32'h4), nr(), o(1,0, 1,32'h1000,0, 0,0,0, 0,1, 32'h4, 0));
        vecs[6]  = mk(rd(32'h8), nr(), o(1,0, 1,32'h1004,0, 0,0,0, 0,1, 32'h8, 0));
        vecs[7]  = mk(nr(), nr(), o(0,0, 1,32'h1008,0, 0,0,0, 0,0, 0, 0));
        vecs[8]  = mk(rd(32'h0), rd(32'h4), o(0,1, 0,0,0, 0,0,0, 0,1, 32'h4, 0));
        vecs[9]  = mk(rd(32'h0), rd(32'h8), o(1,0, 0,0,0, 1,32'h1004,0, 0,1, 32'h0, 0));
        vecs[10] = mk(rd(32'h4), rd(32'h8), o(0,1, 1,32'h1000,0, 0,0,0, 0,1, 32'h8, 0));
        vecs[11] = mk(nr(), nr(), o(0,0, 0,0,0, 1,32'h1008,0, 0,0, 0, 0));
        vecs[12] = mk(nr(), wr(32'h20, 32'h0000AA00, 4'b0010), o(0,1, 0,0,0, 0,0,0, 0,1, 32'h20, 0));
        vecs[13] = mk(rd(32'h0), nr(), o(0,0, 0,0,0, 0,0,0, 1,0, 32'h20, 32'h1122AA44));
        vecs[14] = mk(rd(32'h0), nr(), o(1,0, 0,0,0, 0,0,0, 0,1, 32'h0, 0));
        vecs[15] = mk(rd(32'h20), nr(), o(1,0, 1,32'h1000,0, 0,0,0, 0,1, 32'h20, 0));
        vecs[16] = mk(nr(), nr(), o(0,0, 1,32'h1122AA44,0, 0,0,0, 0,0, 0, 0));
        vecs[17] = mk(nr(), rd(32'h1000), o(0,1, 0,0,0, 0,0,0, 0,0, 0, 0));
        vecs[18] = mk(nr(), wr(32'h1000, 32'hFFFFFFFF, 4'hF), o(0,1, 0,0,0, 1,0,1, 0,0, 0, 0));
        vecs[19] = mk(nr(), wr(32'h1000, 32'hFFFFFFFF, 4'b0010), o(0,1, 0,0,0, 0,0,0, 0,0, 0, 0));
        vecs[20] = mk(rd(32'h0), nr(), o(1,0, 0,0,0, 0,0,0, 0,1, 32'h0, 0));
        vecs[21] = mk(nr(), nr(), o(0,0, 1,32'h1000,0, 0,0,0, 0,0, 0, 0));
        vecs[22] = mk(wr(32'h4, 32'hFFFFFFFF, 4'h0), nr(), o(1,0, 0,0,0, 0,0,0, 0,0, 0, 0));
        vecs[23] = mk(rd(32'h4), nr(), o(1,0, 0,0,0, 0,0,0, 0,1, 32'h4, 0));
        vecs[24] = mk(nr(), nr(), o(0,0, 1,32'h1004,0, 0,0,0, 0,0, 0, 0));

        bus_fp.p0_req = 0; bus_fp.p0_we = 0; bus_fp.p0_addr = 0; bus_fp.p0_wdata = 0; bus_fp.p0_be = 0;
        bus_fp.p1_req = 0; bus_fp.p1_we = 0; bus_fp.p1_addr = 0; bus_fp.p1_wdata = 0; bus_fp.p1_be = 0;

        // Outputs must stay 0 in reset even with requests present
        drive(rd(32'h0), wr(32'h4, 32'h1, 4'hF));
        repeat (2) @(posedge clk);
        #1 chk("reset_outputs_zero", Z);
        loading = 1'b0;
        rst_n = 1'b1;
        drive(nr(), nr());

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].p0, vecs[i].p1);
            @(negedge clk);
            chk($sformatf("vec%0d", i), vecs[i].exp);
            @(posedge clk); #1;
        end

        // Reset in the merge cycle of a read-modify-write
        drive(nr(), wr(32'h20, 32'h000000FF, 4'b0001));
        @(negedge clk);
        chk("rmw_rst_grant", o(0,1, 0,0,0, 0,0,0, 0,1, 32'h20, 0));
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(nr(), nr());
        #1 chk("rmw_rst_outputs_zero", Z);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(rd(32'h20), rd(32'h20));
        @(negedge clk);
        chk("post_rst_first_contention", o(1,0, 0,0,0, 0,0,0, 0,1, 32'h20, 0));
        @(posedge clk); #1;
        drive(nr(), rd(32'h20));
        @(negedge clk);
        chk("post_rst_word_unchanged", o(0,1, 1,32'h1122AA44,0, 0,0,0, 0,1, 32'h20, 0));
        @(posedge clk); #1;
        drive(nr(), nr());
        @(negedge clk);
        chk("post_rst_p1_resp", o(0,0, 0,0,0, 1,32'h1122AA44,0, 0,0, 0, 0));
        @(posedge clk); #1;

        // Fixed priority: port 0 wins every contended cycle
        bus_fp.p0_req = 1'b1; bus_fp.p1_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus_fp.p0_gnt, bus_fp.p1_gnt} !== 2'b10) begin
                failures++;
                $display("FAIL fixed_prio_cyc%0d got=%b exp=10", i, {bus_fp.p0_gnt, bus_fp.p1_gnt});
            end
            @(posedge clk); #1;
        end
        bus_fp.p0_req = 1'b0; bus_fp.p1_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
